instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: AW, default 8, log2 of memory depth in 16-bit words (depth 256).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instrAddrF  input  16  fetch-stage PC, word address, from the datapath.
REQ-005 instrF  output  16  fetched instruction to the datapath, combinational from instrAddrF.
REQ-006 load_valid  input  1  loader word present.
REQ-007 load_data  input  16  loader instruction word.
REQ-008 load_last  input  1  qualifies load_valid; marks the final program word.
REQ-009 load_ready  output  1  block accepts loader words.
REQ-010 reload  input  1  single-cycle request to re-enter loading.
REQ-011 run  output  1  program loaded; datapath may execute; datapath reset is held while low.
REQ-012 words_loaded  output  AW+1  count of valid program words.
REQ-013 addr_err  output  1  sticky flag: fetch outside the loaded program.

Function
REQ-014 The FSM SHALL have two states, LOAD and RUN; run = (state == RUN); load_ready = (state == LOAD).
REQ-015 A word SHALL be accepted on a rising edge with load_valid & load_ready; it is written to mem[wr_ptr], and wr_ptr and words_loaded SHALL increment by 1 at that edge.
REQ-016 LOAD -> RUN SHALL occur at the edge accepting a word with load_last=1, or at the edge accepting the word at wr_ptr = 2^AW-1 (memory full), whichever comes first; run is high from the next cycle.
REQ-017 Full memory without load_last SHALL still enter RUN, with words_loaded = 2^AW; no further writes.
REQ-018 In RUN, load_valid, load_data and load_last SHALL be ignored; memory SHALL NOT be written.
REQ-019 reload=1 in any state SHALL, at that edge, set state to LOAD, wr_ptr to 0, words_loaded to 0, addr_err to 0; memory contents are retained; a load_valid in the same cycle is not accepted.
REQ-020 In RUN, instrF = mem[instrAddrF[AW-1:0]] when instrAddrF < words_loaded (16-bit unsigned compare), else 16'h0000 (NOP).
REQ-021 In LOAD, instrF SHALL be 16'h0000 regardless of address.
REQ-022 addr_err SHALL set at the edge of any RUN cycle in which instrAddrF >= words_loaded, and SHALL stay set until reset or reload.
REQ-023 Reads SHALL be combinational (zero latency); writes SHALL be synchronous; there is no read-during-write case because reads return NOP in LOAD.
REQ-024 words_loaded SHALL saturate at 2^AW; wr_ptr SHALL NOT wrap or overwrite word 0.

Reset
REQ-025 On reset: state = LOAD, wr_ptr = 0, words_loaded = 0, addr_err = 0, load_ready = 1, run = 0, instrF = 0.
REQ-026 Memory array contents SHALL NOT be reset or cleared.
REQ-027 Reset asserted mid-load SHALL discard progress: loading restarts at word 0 on the first cycle after reset deasserts.
REQ-028 Reset SHALL take priority over reload and over a simultaneous loader handshake.

Verification
REQ-029 Reset, then load 3 words 16'h1111, 16'h2222, 16'h3333 (last on third) -> run=1 next cycle, words_loaded=3; instrAddrF=1 -> instrF=16'h2222, addr_err=0.
REQ-030 In RUN with words_loaded=3, instrAddrF=3 then 16'h0100 -> instrF=0 both cycles, addr_err=1 after the first edge and remains 1.
REQ-031 Load 256 words with data = index and no load_last -> run=1 after the 256th acceptance, words_loaded=256; a further load_valid is not written (mem[0] still 0).
REQ-032 Load 2 words with a one-cycle load_valid gap between them; reset mid-load after the first -> words_loaded=0, load_ready=1; reload sequence of 1 word with last -> words_loaded=1.
REQ-033 In RUN, pulse reload with load_valid=1 in the same cycle -> run=0, words_loaded=0, addr_err=0, no word written that cycle; instrF=0 while in LOAD.
REQ-034 load_valid with load_last on the first word after reset -> run=1, words_loaded=1, instrAddrF=0 returns that word.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Fetch port and loader stream of the instruction memory loader.
// master = datapath/loader side, slave = the loader block.
interface instr_mem_loader_if #(
  parameter int unsigned AW = 8
);
  logic [15:0] instrAddrF;
  logic [15:0] instrF;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic        run;
  logic [AW:0] words_loaded;
  logic        addr_err;

  modport master (
    output instrAddrF, load_valid, load_data, load_last, reload,
    input  instrF, load_ready, run, words_loaded, addr_err
  );

  modport slave (
    input  instrAddrF, load_valid, load_data, load_last, reload,
    output instrF, load_ready, run, words_loaded, addr_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory filled by a streaming loader, then read combinationally by the fetch stage.
// Fetches outside the loaded program return NOP and raise a sticky addr_err.
module instr_mem_loader #(
  parameter int unsigned AW = 8
) (
  input logic                 clk,
  input logic                 reset,
  instr_mem_loader_if.slave   bus
);
  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic {StLoad, StRun} state_e;

  state_e          state_q;
  logic [AW:0]     count_q;
  logic [AW-1:0]   wr_ptr_q;
  logic            err_q;
  logic [15:0]     mem [Depth];

  logic accept;
  logic last_word;
  logic at_top;
  logic in_range;

  // reload wins over a same-cycle loader word
  assign accept    = bus.load_valid && (state_q == StLoad) && !bus.reload;
  assign at_top    = (wr_ptr_q == AW'(Depth - 1));
  assign last_word = bus.load_last || at_top;
  assign in_range  = (bus.instrAddrF < 16'(count_q));

  always_ff @(posedge clk) begin
    if (reset || bus.reload) begin
      state_q  <= StLoad;
      count_q  <= '0;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            count_q <= count_q + (AW + 1)'(1);
            // saturate at the top word so word 0 is never overwritten
            if (!at_top) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (last_word) state_q <= StRun;
          end
        end
        StRun: begin
          if (!in_range) err_q <= 1'b1;
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // No reset on the array: contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (accept && !reset) mem[wr_ptr_q] <= bus.load_data;
  end

  assign bus.instrF       = ((state_q == StRun) && in_range) ? mem[bus.instrAddrF[AW-1:0]] : '0;
  assign bus.run          = (state_q == StRun);
  assign bus.load_ready   = (state_q == StLoad);
  assign bus.words_loaded = count_q;
  assign bus.addr_err     = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: stimulus pushes expected observations into a
// scoreboard queue, a negedge monitor pops and compares them against the DUT.
module tb_instr_mem_loader;
  localparam int unsigned AW = 8;

  logic clk;
  logic reset;

  instr_mem_loader_if #(.AW(AW)) bus ();

  instr_mem_loader #(.AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        run;
    logic [AW:0] words;
    logic        err;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   misses  = 0;

  task automatic expect_obs(input string name, input logic run, input int words,
                            input logic err, input logic [15:0] instr);
    exp_t e;
    e.name  = name;
    e.run   = run;
    e.words = (AW + 1)'(words);
    e.err   = err;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_last  = l;
  endtask

  // Monitor: the DUT output is valid for checking at every falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (bus.run !== e.run || bus.load_ready !== !e.run || bus.words_loaded !== e.words ||
          bus.addr_err !== e.err || bus.instrF !== e.instr) begin
        misses++;
        $display("FAIL %s: got run=%b ready=%b words=%0d err=%b instr=%h, want run=%b ready=%b words=%0d err=%b instr=%h",
                 e.name, bus.run, bus.load_ready, bus.words_loaded, bus.addr_err, bus.instrF,
                 e.run, !e.run, e.words, e.err, e.instr);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.instrAddrF = '0;
    bus.reload     = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    step();
    reset = 1'b0;
    expect_obs("reset", 1'b0, 0, 1'b0, 16'h0000);

    // Three-word program, last on the third word
    drive(1'b1, 16'h1111, 1'b0);
    step();
    drive(1'b1, 16'h2222, 1'b0);
    expect_obs("load_one", 1'b0, 1, 1'b0, 16'h0000);
    step();
    drive(1'b1, 16'h3333, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    bus.instrAddrF = 16'd1;
    expect_obs("run_rd1", 1'b1, 3, 1'b0, 16'h2222);
    step();
    bus.instrAddrF = 16'd2;
    expect_obs("run_rd2", 1'b1, 3, 1'b0, 16'h3333);
    step();

    // Out-of-range fetches: NOP, sticky error from the following edge
    bus.instrAddrF = 16'd3;
    expect_obs("oob_3", 1'b1, 3, 1'b0, 16'h0000);
    step();
    bus.instrAddrF = 16'h0100;
    expect_obs("oob_256", 1'b1, 3, 1'b1, 16'h0000);
    step();
    bus.instrAddrF = 16'd0;
    expect_obs("err_sticky", 1'b1, 3, 1'b1, 16'h1111);
    step();

    // Reload with a simultaneous loader word: the word must be dropped
    bus.reload = 1'b1;
    drive(1'b1, 16'hBEEF, 1'b1);
    step();
    bus.reload = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    expect_obs("after_reload", 1'b0, 0, 1'b0, 16'h0000);
    step();
    drive(1'b1, 16'hCAFE, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    bus.instrAddrF = 16'd0;
    expect_obs("reload_single", 1'b1, 1, 1'b0, 16'hCAFE);
    step();

    // Gap between words, then reset mid-load (with a handshake in the same cycle)
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 16'hAAAA, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    expect_obs("gap", 1'b0, 1, 1'b0, 16'h0000);
    step();
    reset = 1'b1;
    drive(1'b1, 16'hBBBB, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    expect_obs("rst_midload", 1'b0, 0, 1'b0, 16'h0000);
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    drive(1'b1, 16'h1234, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    bus.instrAddrF = 16'd0;
    expect_obs("reload_one", 1'b1, 1, 1'b0, 16'h1234);
    step();

    // Fill all 256 words with data = index, no load_last
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      if (i == 255) expect_obs("pre_full", 1'b0, 255, 1'b0, 16'h0000);
      step();
    end
    drive(1'b1, 16'hFFFF, 1'b1);
    bus.instrAddrF = 16'd0;
    expect_obs("full", 1'b1, 256, 1'b0, 16'h0000);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    bus.instrAddrF = 16'h00FF;
    expect_obs("full_top", 1'b1, 256, 1'b0, 16'h00FF);
    step();
    bus.instrAddrF = 16'd0;
    expect_obs("mem0_kept", 1'b1, 256, 1'b0, 16'h0000);
    step();
    bus.instrAddrF = 16'h0100;
    expect_obs("addr_256", 1'b1, 256, 1'b0, 16'h0000);
    step();
    bus.instrAddrF = 16'd5;
    expect_obs("err_256", 1'b1, 256, 1'b1, 16'h0005);
    step();

    // First word after reset carries load_last
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 16'h5A5A, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    bus.instrAddrF = 16'd0;
    expect_obs("first_last", 1'b1, 1, 1'b0, 16'h5A5A);
    step();
    bus.instrAddrF = 16'd1;
    expect_obs("first_oob", 1'b1, 1, 1'b0, 16'h0000);
    step();
    step();

    if (sb.size() != 0) begin
      misses++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
